// File: rtl/eps_greedy_hop_selector_pkg.sv
// Shared types and constants for the epsilon-greedy next-hop selector.
// Holds the FSM encoding, reason codes and the LFSR step function.
package hop_sel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_SCAN,
        ST_DECIDE,
        ST_DONE
    } state_t;

    localparam logic [1:0] REASON_NONE    = 2'd0;
    localparam logic [1:0] REASON_EXPLORE = 2'd1;
    localparam logic [1:0] REASON_BETTER  = 2'd2;
    localparam logic [1:0] REASON_BAND    = 2'd3;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h1ACE_B00C;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/eps_greedy_hop_selector_if.sv
// Request/response bundle between a routing node and its hop selector.
// The master modport is the requester; the slave modport is the selector.
interface eps_greedy_hop_selector_if #(
    parameter int NUM_NBR = 8,
    parameter int ID_W    = 16,
    parameter int VAL_W   = 16
);
    logic                     start;
    logic                     epsilon_load;
    logic [15:0]              epsilon_in;
    logic [15:0]              epsilon_step;
    logic [NUM_NBR-1:0]       nbr_valid;
    logic [NUM_NBR*ID_W-1:0]  nbr_id;
    logic [NUM_NBR*VAL_W-1:0] nbr_value;
    logic [ID_W-1:0]          my_node_id;
    logic [VAL_W-1:0]         my_best;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          nexthop;
    logic                     nexthop_valid;
    logic [1:0]               reason;
    logic [15:0]              epsilon_out;

    modport master (
        output start, epsilon_load, epsilon_in, epsilon_step,
               nbr_valid, nbr_id, nbr_value, my_node_id, my_best,
        input  busy, done, nexthop, nexthop_valid, reason, epsilon_out
    );

    modport slave (
        input  start, epsilon_load, epsilon_in, epsilon_step,
               nbr_valid, nbr_id, nbr_value, my_node_id, my_best,
        output busy, done, nexthop, nexthop_valid, reason, epsilon_out
    );
endinterface

// File: rtl/eps_greedy_hop_selector_lfsr32.sv
// 32-bit Galois LFSR that steps only when advance is high.
module lfsr32
    import hop_sel_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/eps_greedy_hop_selector.sv
// Epsilon-greedy next-hop selector: random eligible neighbour on explore,
// cheapest eligible neighbour (against my_best with a tolerance band) on exploit.
module eps_greedy_hop_selector
    import hop_sel_pkg::*;
#(
    parameter int          NUM_NBR   = 8,
    parameter int          ID_W      = 16,
    parameter int          VAL_W     = 16,
    parameter int          TOL_SHIFT = 10,
    parameter logic [15:0] EPS_INIT  = 16'h0000,
    parameter logic [31:0] SEED      = DEFAULT_SEED
) (
    input logic                        clock,
    input logic                        nreset,
    eps_greedy_hop_selector_if.slave   bus
);

    localparam int CNT_W  = $clog2(NUM_NBR + 1);
    localparam int IDX_W  = $clog2(NUM_NBR);
    localparam int PROD_W = 16 + CNT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NBR - 1);

    state_t state_reg, state_next;

    logic [ID_W-1:0]  id_arr  [NUM_NBR];
    logic [VAL_W-1:0] val_arr [NUM_NBR];
    logic [NUM_NBR-1:0] elig;
    logic [CNT_W-1:0]   cnt;

    logic [31:0]       lfsr_state;
    logic [15:0]       r1, r2;
    logic              draw_explore;
    logic [PROD_W-1:0] draw_prod;
    logic [CNT_W-1:0]  draw_k;

    logic [15:0]      eps_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             explore_reg;
    logic [CNT_W-1:0] k_reg;
    logic [CNT_W-1:0] seen_reg;
    logic [ID_W-1:0]  pick_id_reg;
    logic             found_reg;
    logic [VAL_W-1:0] best_val_reg;
    logic [ID_W-1:0]  best_id_reg;
    logic [ID_W-1:0]  nexthop_reg;
    logic             nh_valid_reg;
    logic [1:0]       reason_reg;

    logic [VAL_W-1:0] tol, lo, hi;
    logic [VAL_W:0]   hi_sum;

    generate
        for (genvar gi = 0; gi < NUM_NBR; gi++) begin : g_entry
            assign id_arr[gi]  = bus.nbr_id[gi*ID_W +: ID_W];
            assign val_arr[gi] = bus.nbr_value[gi*VAL_W +: VAL_W];
            assign elig[gi]    = bus.nbr_valid[gi] && (id_arr[gi] != bus.my_node_id);
        end
    endgenerate

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NUM_NBR; i++) begin
            cnt = cnt + CNT_W'(elig[i]);
        end
    end

    lfsr32 #(.SEED(SEED)) u_lfsr (
        .clock   (clock),
        .nreset  (nreset),
        .advance (state_reg == ST_DRAW),
        .state   (lfsr_state)
    );

    // The draw uses the LFSR word present in DRAW; the step lands at the same edge.
    assign r1           = lfsr_state[31:16];
    assign r2           = lfsr_state[15:0];
    assign draw_explore = (cnt != '0) && ((eps_reg == 16'hFFFF) || (r1 < eps_reg));
    assign draw_prod    = PROD_W'(r2) * PROD_W'(cnt);
    assign draw_k       = draw_prod[PROD_W-1 -: CNT_W];

    // Upper band edge saturates instead of wrapping near the top of the range.
    assign tol    = bus.my_best >> TOL_SHIFT;
    assign lo     = bus.my_best - tol;
    assign hi_sum = {1'b0, bus.my_best} + {1'b0, tol};
    assign hi     = hi_sum[VAL_W] ? {VAL_W{1'b1}} : hi_sum[VAL_W-1:0];

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.start) state_next = ST_DRAW;
            ST_DRAW:   state_next = ST_SCAN;
            ST_SCAN:   if (idx_reg == LAST_IDX) state_next = ST_DECIDE;
            ST_DECIDE: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            eps_reg      <= EPS_INIT;
            idx_reg      <= '0;
            explore_reg  <= 1'b0;
            k_reg        <= '0;
            seen_reg     <= '0;
            pick_id_reg  <= '0;
            found_reg    <= 1'b0;
            best_val_reg <= '0;
            best_id_reg  <= '0;
            nexthop_reg  <= '0;
            nh_valid_reg <= 1'b0;
            reason_reg   <= REASON_NONE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.epsilon_load) eps_reg <= bus.epsilon_in;
                end
                ST_DRAW: begin
                    explore_reg  <= draw_explore;
                    k_reg        <= draw_k;
                    idx_reg      <= '0;
                    seen_reg     <= '0;
                    pick_id_reg  <= '0;
                    found_reg    <= 1'b0;
                    best_val_reg <= '0;
                    best_id_reg  <= '0;
                end
                ST_SCAN: begin
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (elig[idx_reg]) begin
                        seen_reg <= seen_reg + CNT_W'(1);
                        if (seen_reg == k_reg) pick_id_reg <= id_arr[idx_reg];
                        // Strict compare keeps the lowest index on equal costs.
                        if (!found_reg || (val_arr[idx_reg] < best_val_reg)) begin
                            found_reg    <= 1'b1;
                            best_val_reg <= val_arr[idx_reg];
                            best_id_reg  <= id_arr[idx_reg];
                        end
                    end
                end
                ST_DECIDE: begin
                    if (explore_reg) begin
                        nexthop_reg  <= pick_id_reg;
                        nh_valid_reg <= 1'b1;
                        reason_reg   <= REASON_EXPLORE;
                        eps_reg      <= (eps_reg > bus.epsilon_step) ? (eps_reg - bus.epsilon_step) : 16'h0000;
                    end else if (found_reg && (best_val_reg < lo)) begin
                        nexthop_reg  <= best_id_reg;
                        nh_valid_reg <= 1'b1;
                        reason_reg   <= REASON_BETTER;
                    end else if (found_reg && (best_val_reg < hi)) begin
                        nexthop_reg  <= best_id_reg;
                        nh_valid_reg <= 1'b1;
                        reason_reg   <= REASON_BAND;
                    end else begin
                        nexthop_reg  <= bus.my_node_id;
                        nh_valid_reg <= 1'b0;
                        reason_reg   <= REASON_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = (state_reg != ST_IDLE);
    assign bus.done          = (state_reg == ST_DONE);
    assign bus.nexthop       = nexthop_reg;
    assign bus.nexthop_valid = nh_valid_reg;
    assign bus.reason        = reason_reg;
    assign bus.epsilon_out   = eps_reg;

endmodule

// File: tb/tb_eps_greedy_hop_selector.sv
// Directed bench for the hop selector: vector table plus reset, busy and
// explore-distribution sequences on a 4-entry neighbour table.
module tb_eps_greedy_hop_selector;
    import hop_sel_pkg::*;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int VW = 16;
    localparam int EXP_LAT = N + 2;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    eps_greedy_hop_selector_if #(.NUM_NBR(N), .ID_W(IW), .VAL_W(VW)) bus ();

    eps_greedy_hop_selector #(
        .NUM_NBR(N), .ID_W(IW), .VAL_W(VW), .TOL_SHIFT(10),
        .EPS_INIT(16'h0000), .SEED(32'h1ACE_B00C)
    ) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*IW-1:0] ids;
        logic [N*VW-1:0] vals;
        logic [IW-1:0]   my_id;
        logic [VW-1:0]   my_best;
        logic            eps_load;
        logic [15:0]     eps_in;
        logic [15:0]     step;
        logic            any_nbr;
        logic [IW-1:0]   exp_nh;
        logic            exp_valid;
        logic [1:0]      exp_reason;
        logic [15:0]     exp_eps;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic vec_t mk(input logic [3:0] valid, input logic [63:0] ids, input logic [63:0] vals,
                                input int my_best, input logic eps_load, input logic [15:0] eps_in,
                                input logic [15:0] step, input logic any_nbr, input int exp_nh,
                                input logic exp_valid, input logic [1:0] exp_reason, input logic [15:0] exp_eps);
        vec_t v;
        v.valid = valid; v.ids = ids; v.vals = vals; v.my_id = 16'd5;
        v.my_best = my_best[15:0]; v.eps_load = eps_load; v.eps_in = eps_in; v.step = step;
        v.any_nbr = any_nbr; v.exp_nh = exp_nh[15:0]; v.exp_valid = exp_valid;
        v.exp_reason = exp_reason; v.exp_eps = exp_eps;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.nbr_valid    = v.valid;
        bus.nbr_id       = v.ids;
        bus.nbr_value    = v.vals;
        bus.my_node_id   = v.my_id;
        bus.my_best      = v.my_best;
        bus.epsilon_load = v.eps_load;
        bus.epsilon_in   = v.eps_in;
        bus.epsilon_step = v.step;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Issues one request from the current (post-edge) time and checks its result.
    task automatic run_vec(input vec_t v, input string tag, input bit quiet);
        int lat;
        apply(v);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.epsilon_load = 1'b0;
        check({tag, ".busy_hi"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, ".latency"}, 32'(lat), 32'(EXP_LAT));
        if (v.any_nbr) begin
            check({tag, ".nh_in_set"}, 32'((bus.nexthop >= 16'd1) && (bus.nexthop <= 16'd4)), 32'd1);
        end else begin
            check({tag, ".nexthop"}, 32'(bus.nexthop), 32'(v.exp_nh));
        end
        check({tag, ".valid"}, 32'(bus.nexthop_valid), 32'(v.exp_valid));
        check({tag, ".reason"}, 32'(bus.reason), 32'(v.exp_reason));
        check({tag, ".eps"}, 32'(bus.epsilon_out), 32'(v.exp_eps));
        if (!quiet)
            $display("%s: nexthop=%0d valid=%0d reason=%0d eps=%h latency=%0d",
                     tag, bus.nexthop, bus.nexthop_valid, bus.reason, bus.epsilon_out, lat);
        @(posedge clock); #1;
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_lo"}, 32'(bus.busy), 32'd0);
    endtask

    vec_t vecs[12];
    vec_t base;
    int   hits[5];
    int   lat;
    bit   saw_done;

    initial begin
        bus.start = 1'b0;
        bus.epsilon_load = 1'b0;
        bus.epsilon_in = 16'h0;
        bus.epsilon_step = 16'h0;
        bus.nbr_valid = '0;
        bus.nbr_id = '0;
        bus.nbr_value = '0;
        bus.my_node_id = '0;
        bus.my_best = '0;

        //            valid   ids               values                          best    ld eps_in   step     any nh v  rsn eps
        vecs[0]  = mk(4'hF, p4(1,2,3,4), p4(900,1200,800,800),        1000,   1, 16'h0,    16'h0,    0, 3, 1, 2, 16'h0);
        vecs[1]  = mk(4'hF, p4(1,2,3,4), p4(1024,2000,3000,4000),     1024,   0, 16'h0,    16'h0,    0, 1, 1, 3, 16'h0);
        vecs[2]  = mk(4'hF, p4(1,2,3,4), p4(1023,2000,3000,4000),     1024,   0, 16'h0,    16'h0,    0, 1, 1, 3, 16'h0);
        vecs[3]  = mk(4'hF, p4(1,2,3,4), p4(1022,2000,3000,4000),     1024,   0, 16'h0,    16'h0,    0, 1, 1, 2, 16'h0);
        vecs[4]  = mk(4'hF, p4(1,2,3,4), p4(1025,2000,3000,4000),     1024,   0, 16'h0,    16'h0,    0, 5, 0, 0, 16'h0);
        vecs[5]  = mk(4'hF, p4(5,2,3,4), p4(10,900,950,990),          1000,   0, 16'h0,    16'h0,    0, 2, 1, 2, 16'h0);
        vecs[6]  = mk(4'hF, p4(1,2,3,4), p4(900,1200,800,800),        1000,   1, 16'hFFFF, 16'hFFFF, 1, 0, 1, 1, 16'h0);
        vecs[7]  = mk(4'hF, p4(1,2,3,4), p4(900,1200,800,800),        1000,   0, 16'h0,    16'hFFFF, 0, 3, 1, 2, 16'h0);
        vecs[8]  = mk(4'h0, p4(1,2,3,4), p4(900,1200,800,800),        1000,   1, 16'hFFFF, 16'h0001, 0, 5, 0, 0, 16'hFFFF);
        vecs[9]  = mk(4'hF, p4(1,2,3,4), p4(900,1200,800,800),        1000,   0, 16'h0,    16'h1000, 1, 0, 1, 1, 16'hEFFF);
        vecs[10] = mk(4'hF, p4(1,2,3,4), p4(900,800,800,950),         1000,   1, 16'h0,    16'h0,    0, 2, 1, 2, 16'h0);
        vecs[11] = mk(4'hF, p4(1,2,3,4), p4(65534,65535,65535,65535), 65535,  0, 16'h0,    16'h0,    0, 1, 1, 3, 16'h0);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.nexthop", 32'(bus.nexthop), 32'd0);
        check("rst.valid", 32'(bus.nexthop_valid), 32'd0);
        check("rst.reason", 32'(bus.reason), 32'd0);
        check("rst.eps", 32'(bus.epsilon_out), 32'd0);
        $display("reset: busy=%0d done=%0d eps=%h", bus.busy, bus.done, bus.epsilon_out);
        nreset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Explore distribution: 1000 forced explores, epsilon reloaded each time.
        base = vecs[6];
        for (int i = 0; i < 5; i++) hits[i] = 0;
        for (int i = 0; i < 1000; i++) begin
            run_vec(base, "dist", 1'b1);
            if (bus.reason == REASON_EXPLORE && bus.nexthop >= 16'd1 && bus.nexthop <= 16'd4)
                hits[bus.nexthop]++;
        end
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("dist.id%0d_ge150", i), 32'(hits[i] >= 150), 32'd1);
        end
        $display("distribution: id1=%0d id2=%0d id3=%0d id4=%0d", hits[1], hits[2], hits[3], hits[4]);

        // Reset in the middle of SCAN: no done, epsilon back to EPS_INIT.
        base = vecs[6];
        base.step = 16'h0;
        base.exp_eps = 16'hFFFF;
        run_vec(base, "prime_eps", 1'b0);
        apply(vecs[1]);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nreset = 1'b0;
        @(posedge clock); #1;
        nreset = 1'b1;
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.eps", 32'(bus.epsilon_out), 32'd0);
        check("midrst.reason", 32'(bus.reason), 32'd0);
        saw_done = 1'b0;
        for (int n = 0; n < N + 6; n++) begin
            if (bus.done) saw_done = 1'b1;
            @(posedge clock); #1;
        end
        check("midrst.no_done", 32'(saw_done), 32'd0);
        $display("midrst: busy=%0d eps=%h saw_done=%0d", bus.busy, bus.epsilon_out, saw_done);
        run_vec(vecs[0], "after_rst", 1'b0);

        // start/epsilon_load during an operation are ignored.
        apply(vecs[0]);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.epsilon_load = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.epsilon_load = 1'b1;
        bus.epsilon_in = 16'hFFFF;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.epsilon_load = 1'b0;
        wait_done(lat);
        check("busyign.latency", 32'(lat + 2), 32'(EXP_LAT));
        check("busyign.reason", 32'(bus.reason), 32'd2);
        check("busyign.nexthop", 32'(bus.nexthop), 32'd3);
        check("busyign.eps", 32'(bus.epsilon_out), 32'd0);
        saw_done = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clock); #1;
            if (bus.busy || bus.done) saw_done = 1'b1;
        end
        check("busyign.no_restart", 32'(saw_done), 32'd0);
        $display("busyign: nexthop=%0d reason=%0d eps=%h restarted=%0d",
                 bus.nexthop, bus.reason, bus.epsilon_out, saw_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
